sme_job_sequencer: RTL and testbench

Front-end controller for the string-matching engine (SME). Accepts string and pattern records over a byte-wide valid/ready stream that may contain bubbles, and buffers each complete record. It then replays the record to the SME as one contiguous isstring/ispattern burst, waits for the SME verdict with a timeout, and returns a tagged result over a valid/ready handshake.

---
 rtl/sme_job_sequencer.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_sme_job_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_job_sequencer.sv
// sme_job_sequencer
//   Front-end controller for the string-matching engine (SME). It collects one
//   byte-stream record (string or pattern) into a local buffer. It then replays
//   the record to the SME as one gap-free strobe burst. For a pattern it waits
//   for the SME verdict, giving up after TIMEOUT cycles, and presents a tagged
//   result.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid/in_ready           upstream byte handshake
//   in_data, in_type, in_last   record byte, record kind (first byte only), end marker
//   sme_chardata                byte to SME (registered)
//   sme_isstring/sme_ispattern  SME framing strobes (registered)
//   sme_valid, sme_match,
//   sme_match_index             SME verdict
//   res_valid/res_ready         result handshake
//   res_match, res_index        verdict; index forced to 0 on no-match
//   res_timeout, res_nostr      SME silent / pattern before any string
//   res_seq                     pattern ordinal since the last string load
//   err_overflow                one-cycle pulse when an oversize record is dropped
//   busy                        high whenever the sequencer is not idle
module sme_job_sequencer #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_type,
    input  logic       in_last,
    output logic [7:0] sme_chardata,
    output logic       sme_isstring,
    output logic       sme_ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic       res_nostr,
    output logic [7:0] res_seq,
    output logic       err_overflow,
    output logic       busy
);
    localparam int PW = $clog2(STR_MAX + 1);
    localparam int AW = $clog2(STR_MAX);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0] STR_LEN = PW'(STR_MAX);
    localparam logic [PW-1:0] PAT_LEN = PW'(PAT_MAX);
    localparam logic [TW-1:0] TMO_CNT = TW'(TIMEOUT);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_DROP = 3'd2;
    localparam logic [2:0] S_PLAY = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, len_q, len_d;
    logic          rtype_q, rtype_d;
    logic          str_loaded_q, str_loaded_d;
    logic [7:0]    seq_q, seq_d;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          in_ready_q, in_ready_d;
    logic [7:0]    chardata_q, chardata_d;
    logic          isstr_q, isstr_d, ispat_q, ispat_d;
    logic          res_valid_q, res_valid_d;
    logic          res_match_q, res_match_d;
    logic [4:0]    res_index_q, res_index_d;
    logic          res_timeout_q, res_timeout_d;
    logic          res_nostr_q, res_nostr_d;
    logic          err_q, err_d;

    logic [STR_MAX-1:0][7:0] mem_q;
    logic                    mem_we;
    logic [AW-1:0]           mem_wa;

    logic          accept;
    logic          cur_type;
    logic [PW-1:0] max_len;
    logic          start_play;
    logic [PW-1:0] play_len;

    assign accept   = in_valid && in_ready_q;
    // Record kind comes from the first byte; later bytes' in_type is ignored.
    assign cur_type = (state_q == S_IDLE) ? in_type : rtype_q;
    assign max_len  = cur_type ? PAT_LEN : STR_LEN;

    always_comb begin
        state_d       = state_q;
        wp_d          = wp_q;
        rp_d          = rp_q;
        len_d         = len_q;
        rtype_d       = rtype_q;
        str_loaded_d  = str_loaded_q;
        seq_d         = seq_q;
        wcnt_d        = wcnt_q;
        chardata_d    = '0;
        isstr_d       = 1'b0;
        ispat_d       = 1'b0;
        res_valid_d   = res_valid_q;
        res_match_d   = res_match_q;
        res_index_d   = res_index_q;
        res_timeout_d = res_timeout_q;
        res_nostr_d   = res_nostr_q;
        err_d         = 1'b0;
        mem_we        = 1'b0;
        mem_wa        = '0;
        start_play    = 1'b0;
        play_len      = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mem_we  = 1'b1;
                    mem_wa  = '0;
                    wp_d    = PW'(1);
                    rtype_d = in_type;
                    if (in_last) begin
                        start_play = 1'b1;
                        play_len   = PW'(1);
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (wp_q == max_len) begin
                        // Byte max+1: oversize record. A terminating byte ends it here.
                        if (in_last) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else begin
                        mem_we = 1'b1;
                        mem_wa = wp_q[AW-1:0];
                        wp_d   = wp_q + 1'b1;
                        if (in_last) begin
                            start_play = 1'b1;
                            play_len   = wp_q + 1'b1;
                        end
                    end
                end
            end
            S_DROP: begin
                if (accept && in_last) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (rtype_q && !str_loaded_q) begin
                    res_valid_d   = 1'b1;
                    res_nostr_d   = 1'b1;
                    res_match_d   = 1'b0;
                    res_index_d   = '0;
                    res_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (rp_q < len_q) begin
                    chardata_d = mem_q[rp_q[AW-1:0]];
                    isstr_d    = !rtype_q;
                    ispat_d    = rtype_q;
                    rp_d       = rp_q + 1'b1;
                end else if (rtype_q) begin
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    str_loaded_d = 1'b1;
                    seq_d        = '0;
                    state_d      = S_IDLE;
                end
            end
            S_WAIT: begin
                if (sme_valid) begin
                    res_valid_d   = 1'b1;
                    res_match_d   = sme_match;
                    res_index_d   = sme_match ? sme_match_index : 5'd0;
                    res_timeout_d = 1'b0;
                    res_nostr_d   = 1'b0;
                    state_d       = S_RESP;
                end else if (wcnt_q == TMO_CNT) begin
                    res_valid_d   = 1'b1;
                    res_match_d   = 1'b0;
                    res_index_d   = '0;
                    res_timeout_d = 1'b1;
                    res_nostr_d   = 1'b0;
                    state_d       = S_RESP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_d   = 1'b0;
                    res_match_d   = 1'b0;
                    res_index_d   = '0;
                    res_timeout_d = 1'b0;
                    res_nostr_d   = 1'b0;
                    seq_d         = seq_q + 8'd1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The first playback byte is launched on the same edge that accepts the
        // last input byte. A one-byte record is not in the buffer yet, so it is
        // taken straight from the input.
        if (start_play) begin
            state_d = S_PLAY;
            len_d   = play_len;
            rp_d    = PW'(1);
            if (!(cur_type && !str_loaded_q)) begin
                chardata_d = (state_q == S_IDLE) ? in_data : mem_q[0];
                isstr_d    = !cur_type;
                ispat_d    = cur_type;
            end
        end

        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DROP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wp_q          <= '0;
            rp_q          <= '0;
            len_q         <= '0;
            rtype_q       <= 1'b0;
            str_loaded_q  <= 1'b0;
            seq_q         <= '0;
            wcnt_q        <= '0;
            in_ready_q    <= 1'b0;
            chardata_q    <= '0;
            isstr_q       <= 1'b0;
            ispat_q       <= 1'b0;
            res_valid_q   <= 1'b0;
            res_match_q   <= 1'b0;
            res_index_q   <= '0;
            res_timeout_q <= 1'b0;
            res_nostr_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wp_q          <= wp_d;
            rp_q          <= rp_d;
            len_q         <= len_d;
            rtype_q       <= rtype_d;
            str_loaded_q  <= str_loaded_d;
            seq_q         <= seq_d;
            wcnt_q        <= wcnt_d;
            in_ready_q    <= in_ready_d;
            chardata_q    <= chardata_d;
            isstr_q       <= isstr_d;
            ispat_q       <= ispat_d;
            res_valid_q   <= res_valid_d;
            res_match_q   <= res_match_d;
            res_index_q   <= res_index_d;
            res_timeout_q <= res_timeout_d;
            res_nostr_q   <= res_nostr_d;
            err_q         <= err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
        end else if (mem_we) begin
            mem_q[mem_wa] <= in_data;
        end
    end

    assign in_ready      = in_ready_q;
    assign sme_chardata  = chardata_q;
    assign sme_isstring  = isstr_q;
    assign sme_ispattern = ispat_q;
    assign res_valid     = res_valid_q;
    assign res_match     = res_match_q;
    assign res_index     = res_index_q;
    assign res_timeout   = res_timeout_q;
    assign res_nostr     = res_nostr_q;
    assign res_seq       = seq_q;
    assign err_overflow  = err_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_sme_job_sequencer.sv
module tb_sme_job_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_type = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] sme_chardata;
    logic       sme_isstring, sme_ispattern;
    logic       sme_valid = 1'b0;
    logic       sme_match = 1'b0;
    logic [4:0] sme_match_index = 5'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_timeout, res_nostr;
    logic [7:0] res_seq;
    logic       err_overflow, busy;

    sme_job_sequencer #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_type(in_type), .in_last(in_last),
        .sme_chardata(sme_chardata), .sme_isstring(sme_isstring), .sme_ispattern(sme_ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
        .res_index(res_index), .res_timeout(res_timeout), .res_nostr(res_nostr),
        .res_seq(res_seq), .err_overflow(err_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       match;
        logic [4:0] index;
        logic       timeout;
        logic       nostr;
        logic [7:0] seq;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_seq = 8'd0;

    // SME model controls
    logic       sme_answer = 1'b1;
    logic       ans_match = 1'b0;
    logic [4:0] ans_idx = 5'd0;
    int         sme_cd = 0;

    // Output monitor
    int         cyc = 0, s_cycles = 0, p_cycles = 0, s_bursts = 0, p_bursts = 0, err_pulses = 0;
    int         wait_entry_cyc = 0, rv_rise_cyc = 0;
    logic       prev_s = 1'b0, prev_p = 1'b0, prev_rv = 1'b0;
    logic [7:0] s_bytes[$];
    logic [7:0] p_bytes[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sme_isstring === 1'b1) begin
            s_cycles <= s_cycles + 1;
            s_bytes.push_back(sme_chardata);
            if (!prev_s) s_bursts <= s_bursts + 1;
        end
        if (sme_ispattern === 1'b1) begin
            p_cycles <= p_cycles + 1;
            p_bytes.push_back(sme_chardata);
            if (!prev_p) p_bursts <= p_bursts + 1;
        end
        if (err_overflow === 1'b1) err_pulses <= err_pulses + 1;
        if (prev_p && sme_ispattern === 1'b0) wait_entry_cyc <= cyc;
        if (res_valid === 1'b1 && !prev_rv) rv_rise_cyc <= cyc;
        prev_s  <= (sme_isstring === 1'b1);
        prev_p  <= (sme_ispattern === 1'b1);
        prev_rv <= (res_valid === 1'b1);
    end

    // SME answers three cycles after the pattern strobe drops
    always @(negedge clk) begin
        sme_valid <= 1'b0;
        if (sme_cd > 0) begin
            if (sme_cd == 1) begin
                sme_valid       <= 1'b1;
                sme_match       <= ans_match;
                sme_match_index <= ans_idx;
            end
            sme_cd <= sme_cd - 1;
        end else if (prev_p && sme_ispattern === 1'b0 && sme_answer) begin
            sme_cd <= 3;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic t, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_type = t; in_last = l;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_bound", (n < 200), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_rec(input string s, input logic t, input logic gaps);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], t, (i == s.len() - 1));
            if (gaps && i != s.len() - 1) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    // n-byte record; in_type is inverted after the first byte and must not matter
    task automatic send_n(input int n, input logic t, input logic [7:0] base);
        for (int i = 0; i < n; i++)
            send_byte(base + 8'(i % 26), (i == 0) ? t : ~t, (i == n - 1));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0 || sme_isstring !== 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (n < 300), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic push_exp(input logic m, input logic [4:0] idx, input logic to, input logic ns);
        exp_t e;
        e.match = m; e.index = idx; e.timeout = to; e.nostr = ns; e.seq = exp_seq;
        sb.push_back(e);
    endtask

    task automatic get_result(input string tag, input int hold);
        int   n = 0;
        exp_t e;
        while (res_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_sb"}, (sb.size() > 0), 1);
        if (res_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i <= hold; i++) begin
                chk({tag, "_match"}, res_match, e.match);
                chk({tag, "_index"}, res_index, e.index);
                chk({tag, "_timeout"}, res_timeout, e.timeout);
                chk({tag, "_nostr"}, res_nostr, e.nostr);
                chk({tag, "_seq"}, res_seq, e.seq);
                if (i < hold) begin
                    chk({tag, "_hold_valid"}, res_valid, 1);
                    chk({tag, "_hold_in_ready"}, in_ready, 0);
                    @(negedge clk);
                end
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk({tag, "_valid_clr"}, res_valid, 0);
            chk({tag, "_in_ready_after"}, in_ready, 1);
            exp_seq = exp_seq + 8'd1;
        end
    endtask

    initial begin
        int sc, pc, sbu, pbu, ec, sq, pq;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_str", sme_isstring, 0);
        chk("rst_pat", sme_ispattern, 0);
        chk("rst_char", sme_chardata, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_fields", {res_match, res_index, res_timeout, res_nostr, res_seq}, 0);
        chk("rst_err", err_overflow, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);

        // Pattern before any string: no playback, nostr result
        pc = p_cycles;
        push_exp(1'b0, 5'd0, 1'b0, 1'b1);
        send_rec("xy", 1'b1, 1'b0);
        get_result("nostr", 0);
        chk("nostr_no_strobe", p_cycles - pc, 0);

        // String "abcd" with input gaps
        sc = s_cycles; sbu = s_bursts; sq = s_bytes.size();
        send_rec("abcd", 1'b0, 1'b1);
        wait_idle("str_idle");
        exp_seq = 8'd0;
        chk("str_cycles", s_cycles - sc, 4);
        chk("str_bursts", s_bursts - sbu, 1);
        chk("str_b0", s_bytes[sq + 0], 8'h61);
        chk("str_b1", s_bytes[sq + 1], 8'h62);
        chk("str_b2", s_bytes[sq + 2], 8'h63);
        chk("str_b3", s_bytes[sq + 3], 8'h64);
        chk("str_no_result", res_valid, 0);

        // Pattern "b.d" matched at index 1
        ans_match = 1'b1; ans_idx = 5'd1;
        pc = p_cycles; pbu = p_bursts; pq = p_bytes.size();
        push_exp(1'b1, 5'd1, 1'b0, 1'b0);
        send_rec("b.d", 1'b1, 1'b1);
        get_result("bd", 0);
        chk("bd_cycles", p_cycles - pc, 3);
        chk("bd_bursts", p_bursts - pbu, 1);
        chk("bd_b0", p_bytes[pq + 0], 8'h62);
        chk("bd_b1", p_bytes[pq + 1], 8'h2e);
        chk("bd_b2", p_bytes[pq + 2], 8'h64);

        // No match: index forced to 0
        ans_match = 1'b0; ans_idx = 5'd7;
        push_exp(1'b0, 5'd0, 1'b0, 1'b0);
        send_rec("q", 1'b1, 1'b0);
        get_result("nomatch", 0);

        // 33-byte string overflow, last byte terminates it
        sc = s_cycles; ec = err_pulses;
        send_n(33, 1'b0, 8'h41);
        wait_idle("ovf_idle");
        chk("ovf_err_pulses", err_pulses - ec, 1);
        chk("ovf_no_strobe", s_cycles - sc, 0);
        chk("ovf_no_result", res_valid, 0);

        // Previously stored string still counts
        ans_match = 1'b1; ans_idx = 5'd2;
        pc = p_cycles;
        push_exp(1'b1, 5'd2, 1'b0, 1'b0);
        send_rec("cd", 1'b1, 1'b0);
        get_result("after_ovf", 0);
        chk("after_ovf_cycles", p_cycles - pc, 2);

        // 10-byte pattern passes through DROP
        pc = p_cycles; ec = err_pulses;
        send_n(10, 1'b1, 8'h61);
        wait_idle("pdrop_idle");
        chk("pdrop_err", err_pulses - ec, 1);
        chk("pdrop_no_strobe", p_cycles - pc, 0);
        chk("pdrop_no_result", res_valid, 0);

        // Exactly PAT_MAX bytes is legal
        ans_match = 1'b0; ans_idx = 5'd9;
        pc = p_cycles; pbu = p_bursts; ec = err_pulses;
        push_exp(1'b0, 5'd0, 1'b0, 1'b0);
        send_n(8, 1'b1, 8'h61);
        get_result("pmax", 0);
        chk("pmax_cycles", p_cycles - pc, 8);
        chk("pmax_bursts", p_bursts - pbu, 1);
        chk("pmax_no_err", err_pulses - ec, 0);

        // Timeout, then result held 10 cycles
        sme_answer = 1'b0;
        push_exp(1'b0, 5'd0, 1'b1, 1'b0);
        send_rec("zz", 1'b1, 1'b0);
        get_result("tmo", 10);
        chk("tmo_latency", rv_rise_cyc - wait_entry_cyc, 65);
        sme_answer = 1'b1;

        // Fresh string, then 257 patterns: ordinal wraps to 0
        send_rec("ab", 1'b0, 1'b0);
        wait_idle("wrap_str_idle");
        exp_seq = 8'd0;
        ans_match = 1'b1; ans_idx = 5'd3;
        pq = p_bytes.size();
        for (int i = 0; i < 257; i++) begin
            push_exp(1'b1, 5'd3, 1'b0, 1'b0);
            send_rec("p", 1'b1, 1'b0);
            get_result((i == 256) ? "wrap_last" : "wrap", 0);
        end
        chk("wrap_byte", p_bytes[pq], 8'h70);
        chk("wrap_seq_after", res_seq, 1);

        // Reset in the middle of a string playback
        send_n(20, 1'b0, 8'h41);
        repeat (4) @(negedge clk);
        chk("midplay_strobe", sme_isstring, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_str", sme_isstring, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_seq = 8'd0;
        repeat (2) @(negedge clk);
        pc = p_cycles;
        push_exp(1'b0, 5'd0, 1'b0, 1'b1);
        send_rec("xy", 1'b1, 1'b0);
        get_result("post_rst", 0);
        chk("post_rst_no_strobe", p_cycles - pc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
